// File: rtl/pin_bitperm_seq_pkg.sv
// Shared definitions for the pin bit-permutation engine and its bench.
// Holds the mode encodings, the FSM state type and a sizing helper.
package pin_bitperm_seq_pkg;

    localparam logic MODE_DECOMP = 1'b0;
    localparam logic MODE_COMP   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/pin_bitperm_chunk.sv
// Combinational processor for STEP consecutive mask positions: deposits data bits
// (decompress) or scatters chunk bits into accumulator slots (compress), advancing ptr.
module pin_bitperm_chunk
    import pin_bitperm_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 4
) (
    input  logic                       mode_i,
    input  logic [STEP-1:0]            mask_i,
    input  logic [STEP-1:0]            valid_i,
    input  logic [STEP-1:0]            chunk_data_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic [$clog2(WIDTH+1)-1:0] ptr_i,
    output logic [STEP-1:0]            dep_o,
    output logic [WIDTH-1:0]           scat_o,
    output logic [$clog2(WIDTH+1)-1:0] cnt_o,
    output logic [$clog2(WIDTH+1)-1:0] ptr_o
);

    localparam int PW = $clog2(WIDTH + 1);

    logic [PW-1:0] ptr_w;

    always_comb begin
        // NOTE: blocking assignments carry the running pointer from one position to the
        // next within one evaluation; every output is defaulted first so no latch forms.
        dep_o  = '0;
        scat_o = '0;
        cnt_o  = '0;
        ptr_w  = ptr_i;
        for (int j = 0; j < STEP; j++) begin
            if (mask_i[j] && valid_i[j]) begin
                // ptr_w only reaches WIDTH after the final set bit, so it never indexes past data.
                if (mode_i == MODE_DECOMP) begin
                    dep_o[j] = 1'(data_i >> ptr_w);
                end else begin
                    scat_o = scat_o | (WIDTH'(chunk_data_i[j]) << ptr_w);
                end
                ptr_w = ptr_w + PW'(1);
                cnt_o = cnt_o + PW'(1);
            end
        end
        ptr_o = ptr_w;
    end

endmodule

// File: rtl/pin_bitperm_seq.sv
// Iterative handshaked deposit/extract engine: STEP mask positions per clock,
// result and mask popcount presented in DONE until the consumer accepts them.
module pin_bitperm_seq
    import pin_bitperm_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_mode,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [WIDTH-1:0]           in_mask,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(WIDTH+1)-1:0] out_count
);

    localparam int NSTEP = ceil_div(WIDTH, STEP);
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int POSW  = $clog2(NSTEP * STEP + 1);
    localparam logic [POSW-1:0] LAST_POS = POSW'((NSTEP - 1) * STEP);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [POSW-1:0]  pos_q, pos_d;
    logic [CW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [STEP-1:0]  chunk_mask, chunk_valid, chunk_data, chunk_dep;
    logic [WIDTH-1:0] chunk_scat;
    logic [CW-1:0]    chunk_cnt, chunk_ptr;
    logic             ready_c;

    assign chunk_mask = STEP'(mask_q >> pos_q);
    assign chunk_data = STEP'(data_q >> pos_q);

    // Positions past WIDTH in a partial last chunk must contribute nothing.
    always_comb begin
        chunk_valid = '0;
        for (int j = 0; j < STEP; j++) begin
            chunk_valid[j] = (int'(pos_q) + j) < WIDTH;
        end
    end

    pin_bitperm_chunk #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_chunk (
        .mode_i       (mode_q),
        .mask_i       (chunk_mask),
        .valid_i      (chunk_valid),
        .chunk_data_i (chunk_data),
        .data_i       (data_q),
        .ptr_i        (ptr_q),
        .dep_o        (chunk_dep),
        .scat_o       (chunk_scat),
        .cnt_o        (chunk_cnt),
        .ptr_o        (chunk_ptr)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        data_d    = data_q;
        mask_d    = mask_q;
        acc_d     = acc_q;
        pos_d     = pos_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ready_c   = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                    mode_d  = in_mode;
                    data_d  = in_data;
                    mask_d  = in_mask;
                    acc_d   = '0;
                    pos_d   = '0;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (mode_q == MODE_DECOMP) begin
                    acc_d = acc_q | (WIDTH'(chunk_dep) << pos_q);
                end else begin
                    acc_d = acc_q | chunk_scat;
                end
                ptr_d = chunk_ptr;
                cnt_d = cnt_q + chunk_cnt;
                pos_d = pos_q + POSW'(STEP);
                if (pos_q == LAST_POS) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_DECOMP;
            data_q  <= '0;
            mask_q  <= '0;
            acc_q   <= '0;
            pos_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            acc_q   <= acc_d;
            pos_q   <= pos_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gating with rst_n keeps in_ready low while reset is held, not just after an edge.
    assign in_ready  = ready_c & rst_n;
    assign out_data  = acc_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_pin_bitperm_seq.sv
// Bench for pin_bitperm_seq: directed cases on the default configuration plus
// randomized traffic on several WIDTH/STEP configurations against a formula model.
module tb_pin_bitperm_seq;
    import pin_bitperm_seq_pkg::*;

    localparam int DW  = 16;
    localparam int DS  = 4;
    localparam int DNS = ceil_div(DW, DS);
    localparam int DCW = $clog2(DW + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int cfg_w(input int g);
        return (g == 0) ? 13 : 16;
    endfunction

    function automatic int cfg_s(input int g);
        case (g)
            0:       return 5;
            1:       return 1;
            2:       return 3;
            default: return 16;
        endcase
    endfunction

    // Direct form of the definition: k(i) is the popcount of the mask below position i.
    function automatic logic [31:0] ref_perm(input logic m, input logic [31:0] d,
                                             input logic [31:0] mk, input int w);
        logic [31:0] r;
        logic [31:0] below;
        r = '0;
        for (int i = 0; i < w; i++) begin
            if (mk[i]) begin
                below = mk & ((32'd1 << i) - 32'd1);
                if (m == MODE_DECOMP) r[i] = d[$countones(below)];
                else                  r[$countones(below)] = d[i];
            end
        end
        return r;
    endfunction

    // ---------------- default configuration, directed ----------------
    logic           d_rst_n, d_vld, d_rdy, d_mode, d_ovld, d_ordy;
    logic [DW-1:0]  d_data, d_mask, d_odata;
    logic [DCW-1:0] d_ocnt;

    pin_bitperm_seq #(.WIDTH(DW), .STEP(DS)) u_dut (
        .clk       (clk),
        .rst_n     (d_rst_n),
        .in_valid  (d_vld),
        .in_ready  (d_rdy),
        .in_mode   (d_mode),
        .in_data   (d_data),
        .in_mask   (d_mask),
        .out_valid (d_ovld),
        .out_ready (d_ordy),
        .out_data  (d_odata),
        .out_count (d_ocnt)
    );

    task automatic d_send(input logic m, input logic [DW-1:0] dt, input logic [DW-1:0] mk);
        d_mode = m;
        d_data = dt;
        d_mask = mk;
        d_vld  = 1'b1;
        check("d accept ready", d_rdy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        d_vld  = 1'b0;
        d_mode = ~m;
        d_data = ~dt;
        d_mask = ~mk;
    endtask

    task automatic d_wait(output int lat);
        lat = 0;
        while (!d_ovld && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic d_txn(input string tag, input logic m, input logic [DW-1:0] dt,
                         input logic [DW-1:0] mk, input logic [DW-1:0] exp_d, input int exp_c);
        int lat;
        d_send(m, dt, mk);
        d_wait(lat);
        check({tag, " latency"}, lat, DNS);
        check({tag, " data"}, d_odata, exp_d);
        check({tag, " count"}, d_ocnt, exp_c);
        d_ordy = 1'b1;
        @(negedge clk);
        d_ordy = 1'b0;
        check({tag, " valid drop"}, d_ovld, 1'b0);
        check({tag, " ready back"}, d_rdy, 1'b1);
        check({tag, " data held"}, d_odata, exp_d);
    endtask

    // ---------------- randomized configurations ----------------
    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int W   = cfg_w(g);
        localparam int S   = cfg_s(g);
        localparam int NS  = (W + S - 1) / S;
        localparam int NTX = (g == 0) ? 50 : 334;

        logic                   r_rst_n, r_vld, r_rdy, r_mode, r_ovld, r_ordy;
        logic [W-1:0]           r_data, r_mask, r_odata;
        logic [$clog2(W+1)-1:0] r_ocnt;
        bit                     done;

        pin_bitperm_seq #(.WIDTH(W), .STEP(S)) u_dut (
            .clk       (clk),
            .rst_n     (r_rst_n),
            .in_valid  (r_vld),
            .in_ready  (r_rdy),
            .in_mode   (r_mode),
            .in_data   (r_data),
            .in_mask   (r_mask),
            .out_valid (r_ovld),
            .out_ready (r_ordy),
            .out_data  (r_odata),
            .out_count (r_ocnt)
        );

        task automatic txn(input logic m, input logic [W-1:0] dt, input logic [W-1:0] mk,
                           input logic [W-1:0] exp_d, input int exp_c);
            int lat;
            repeat ($urandom_range(0, 2)) begin
                r_data = W'($urandom);
                r_mask = W'($urandom);
                @(negedge clk);
            end
            r_mode = m;
            r_data = dt;
            r_mask = mk;
            r_vld  = 1'b1;
            check($sformatf("W%0d S%0d ready", W, S), r_rdy, 1'b1);
            @(posedge clk);
            @(negedge clk);
            lat = 0;
            while (!r_ovld && lat < 4 * NS + 8) begin
                r_vld  = 1'($urandom_range(0, 1));
                r_mode = 1'($urandom_range(0, 1));
                r_data = W'($urandom);
                r_mask = W'($urandom);
                @(negedge clk);
                lat++;
            end
            check($sformatf("W%0d S%0d latency", W, S), lat, NS);
            check($sformatf("W%0d S%0d data", W, S), r_odata, exp_d);
            check($sformatf("W%0d S%0d count", W, S), r_ocnt, exp_c);
            repeat ($urandom_range(0, 3)) begin
                r_vld  = 1'($urandom_range(0, 1));
                r_data = W'($urandom);
                @(negedge clk);
            end
            check($sformatf("W%0d S%0d held valid", W, S), r_ovld, 1'b1);
            check($sformatf("W%0d S%0d held data", W, S), r_odata, exp_d);
            r_vld  = 1'b0;
            r_ordy = 1'b1;
            @(negedge clk);
            r_ordy = 1'b0;
            check($sformatf("W%0d S%0d valid drop", W, S), r_ovld, 1'b0);
            check($sformatf("W%0d S%0d ready back", W, S), r_rdy, 1'b1);
        endtask

        initial begin
            logic         m;
            logic [W-1:0] dt, mk;
            done    = 1'b0;
            r_rst_n = 1'b1;
            r_vld   = 1'b0;
            r_ordy  = 1'b0;
            r_mode  = MODE_DECOMP;
            r_data  = '0;
            r_mask  = '0;
            #1 r_rst_n = 1'b0;
            repeat (2) @(negedge clk);
            r_rst_n = 1'b1;
            @(negedge clk);
            txn(MODE_COMP,   W'(16'h1ABC), '1, W'(16'h1ABC), W);
            txn(MODE_DECOMP, W'(16'h1ABC), '1, W'(16'h1ABC), W);
            txn(MODE_COMP,   W'(16'h1ABC), '0, '0, 0);
            txn(MODE_DECOMP, W'(16'h1ABC), '0, '0, 0);
            for (int t = 0; t < NTX; t++) begin
                m  = 1'($urandom_range(0, 1));
                dt = W'($urandom);
                case ($urandom_range(0, 3))
                    0:       mk = W'($urandom);
                    1:       mk = W'($urandom & $urandom);
                    2:       mk = W'($urandom | $urandom);
                    default: mk = W'($urandom & $urandom & $urandom);
                endcase
                txn(m, dt, mk, W'(ref_perm(m, 32'(dt), 32'(mk), W)), $countones(mk));
            end
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int budget;
        d_rst_n = 1'b1;
        d_vld   = 1'b0;
        d_ordy  = 1'b0;
        d_mode  = MODE_DECOMP;
        d_data  = '0;
        d_mask  = '0;
        #1 d_rst_n = 1'b0;
        #1;
        check("reset in_ready", d_rdy, 1'b0);
        check("reset out_valid", d_ovld, 1'b0);
        check("reset out_data", d_odata, 16'h0);
        check("reset out_count", d_ocnt, 0);
        repeat (2) @(negedge clk);
        d_rst_n = 1'b1;
        #1;
        check("release in_ready", d_rdy, 1'b1);
        @(negedge clk);

        d_txn("decomp", MODE_DECOMP, 16'h000B, 16'h5145, 16'h0105, 6);
        d_txn("comp",   MODE_COMP,   16'h0105, 16'h5145, 16'h000B, 6);
        d_txn("ones decomp", MODE_DECOMP, 16'hA5C3, 16'hFFFF, 16'hA5C3, 16);
        d_txn("ones comp",   MODE_COMP,   16'hA5C3, 16'hFFFF, 16'hA5C3, 16);
        d_txn("zero mask",   MODE_DECOMP, 16'hA5C3, 16'h0000, 16'h0000, 0);

        // Backpressure: DONE must hold for as long as out_ready stays low.
        d_send(MODE_COMP, 16'h0105, 16'h5145);
        d_wait(lat);
        check("bp latency", lat, DNS);
        repeat (10) begin
            d_vld  = 1'b1;
            d_data = 16'($urandom);
            d_mask = 16'($urandom);
            @(negedge clk);
            check("bp out_valid", d_ovld, 1'b1);
            check("bp out_data", d_odata, 16'h000B);
            check("bp out_count", d_ocnt, 6);
            check("bp in_ready", d_rdy, 1'b0);
        end
        d_vld  = 1'b0;
        d_ordy = 1'b1;
        @(negedge clk);
        d_ordy = 1'b0;
        check("bp release valid", d_ovld, 1'b0);
        check("bp release ready", d_rdy, 1'b1);
        d_txn("after bp", MODE_DECOMP, 16'h000B, 16'h5145, 16'h0105, 6);

        // Asynchronous reset in the second RUN cycle, away from any clock edge.
        d_send(MODE_DECOMP, 16'hFFFF, 16'hFFFF);
        @(posedge clk);
        #2;
        check("pre-reset partial acc", d_odata, 16'h000F);
        d_rst_n = 1'b0;
        #1;
        check("async rst in_ready", d_rdy, 1'b0);
        check("async rst out_valid", d_ovld, 1'b0);
        check("async rst out_data", d_odata, 16'h0);
        check("async rst out_count", d_ocnt, 0);
        @(negedge clk);
        @(negedge clk);
        d_rst_n = 1'b1;
        #1;
        check("post-rst in_ready", d_rdy, 1'b1);
        @(negedge clk);
        d_txn("post-rst comp", MODE_COMP, 16'h0105, 16'h5145, 16'h000B, 6);

        budget = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done)
               && budget < 60000) begin
            @(negedge clk);
            budget++;
        end
        check("random runs complete",
              32'(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
